// File: rtl/chimera_spi_resp_pkg.sv
// Shared opcodes and FSM state type for the SPI serial-flash responder.
package chimera_spi_resp_pkg;

  localparam logic [7:0] OpRead = 8'h03;
  localparam logic [7:0] OpProg = 8'h02;
  localparam logic [7:0] OpRdid = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_PROG,
    ST_RDID,
    ST_IGNORE
  } state_e;

  function automatic logic op_supported(input logic [7:0] op);
    return (op == OpRead) || (op == OpProg) || (op == OpRdid);
  endfunction

endpackage

// File: rtl/chimera_spi_resp_sync.sv
// Two-flop synchronizer for an asynchronous SPI line, plus a third flop for
// rising/falling edge detection of the synchronized level.
module chimera_spi_resp_sync #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] pipe_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_reg <= {3{RstVal}};
    end else begin
      pipe_reg <= {pipe_reg[1:0], d_i};
    end
  end

  assign q_o    = pipe_reg[1];
  assign rise_o = pipe_reg[1] & ~pipe_reg[2];
  assign fall_o = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/chimera_spi_flash_resp.sv
// Minimal mode-0 SPI serial-flash target: READ, PAGE-PROGRAM and READ-ID
// served from an internal byte memory, with a backdoor preload/check port.
module chimera_spi_flash_resp
  import chimera_spi_resp_pkg::*;
#(
  parameter int unsigned MemBytes  = 256,
  parameter int unsigned AddrWidth = $clog2(MemBytes),
  parameter logic [23:0] JedecId   = 24'hC2_20_18
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 spi_csb_i,
  input  logic                 spi_sck_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic                 spi_miso_en_o,
  input  logic                 mem_we_i,
  input  logic [AddrWidth-1:0] mem_addr_i,
  input  logic [7:0]           mem_wdata_i,
  output logic [7:0]           mem_rdata_o,
  output logic                 busy_o,
  output logic                 cmd_err_o
);

  logic csb_s, csb_rise, csb_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_meta_reg, mosi_s_reg;

  // csb flops reset low so a csb already held low at reset release never
  // produces a falling edge; a fresh high-to-low transition is required.
  chimera_spi_resp_sync #(.RstVal(1'b0)) u_sync_csb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_csb_i),
    .q_o    (csb_s),
    .rise_o (csb_rise),
    .fall_o (csb_fall)
  );

  chimera_spi_resp_sync #(.RstVal(1'b0)) u_sync_sck (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_sck_i),
    .q_o    (sck_level_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mosi_meta_reg <= 1'b0;
      mosi_s_reg    <= 1'b0;
    end else begin
      mosi_meta_reg <= spi_mosi_i;
      mosi_s_reg    <= mosi_meta_reg;
    end
  end

  logic [7:0] mem [MemBytes];

  state_e                 state_reg, state_next;
  logic [4:0]             bit_cnt_reg, bit_cnt_next;
  logic [7:0]             rx_reg, rx_next;
  logic [7:0]             op_reg, op_next;
  logic [AddrWidth-1:0]   addr_reg, addr_next;
  logic [7:0]             tx_reg, tx_next;
  logic [1:0]             id_idx_reg, id_idx_next;
  logic                   miso_reg, miso_next;
  logic                   miso_en_reg, miso_en_next;
  logic                   cmd_err_reg, cmd_err_next;
  logic                   spi_we;

  logic [7:0]             rx_shift;
  logic [AddrWidth-1:0]   addr_shift;
  logic [AddrWidth-1:0]   addr_inc;
  logic [7:0]             id_byte;

  assign rx_shift   = {rx_reg[6:0], mosi_s_reg};
  // Only the low address bits are retained; upper address bits alias.
  assign addr_shift = {addr_reg[AddrWidth-2:0], mosi_s_reg};
  assign addr_inc   = addr_reg + 1'b1;
  assign id_byte    = (id_idx_reg == 2'd1) ? JedecId[15:8] :
                      (id_idx_reg == 2'd2) ? JedecId[7:0]  : 8'h00;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    rx_next      = rx_reg;
    op_next      = op_reg;
    addr_next    = addr_reg;
    tx_next      = tx_reg;
    id_idx_next  = id_idx_reg;
    miso_next    = miso_reg;
    miso_en_next = miso_en_reg;
    cmd_err_next = 1'b0;
    spi_we       = 1'b0;
    if (csb_rise) begin
      state_next   = ST_IDLE;
      miso_next    = 1'b0;
      miso_en_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (csb_fall) begin
            state_next   = ST_CMD;
            bit_cnt_next = '0;
            rx_next      = '0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            rx_next      = rx_shift;
            bit_cnt_next = bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd7) begin
              bit_cnt_next = '0;
              op_next      = rx_shift;
              if (!op_supported(rx_shift)) begin
                state_next   = ST_IGNORE;
                cmd_err_next = 1'b1;
              end else if (rx_shift == OpRdid) begin
                state_next  = ST_RDID;
                tx_next     = JedecId[23:16];
                id_idx_next = 2'd1;
              end else begin
                state_next = ST_ADDR;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            addr_next    = addr_shift;
            bit_cnt_next = bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd23) begin
              bit_cnt_next = '0;
              if (op_reg == OpRead) begin
                state_next = ST_READ;
                tx_next    = mem[addr_shift];
              end else begin
                state_next = ST_PROG;
              end
            end
          end
        end
        ST_READ, ST_RDID: begin
          // bit_cnt counts bits driven in the current byte; the reload
          // waits for the rise on which the host samples the last bit.
          if (sck_fall && (bit_cnt_reg != 5'd8)) begin
            miso_next    = tx_reg[7];
            miso_en_next = 1'b1;
            tx_next      = {tx_reg[6:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 5'd1;
          end else if (sck_rise && (bit_cnt_reg == 5'd8)) begin
            bit_cnt_next = '0;
            if (state_reg == ST_READ) begin
              addr_next = addr_inc;
              tx_next   = mem[addr_inc];
            end else begin
              tx_next = id_byte;
              if (id_idx_reg != 2'd3) begin
                id_idx_next = id_idx_reg + 2'd1;
              end
            end
          end
        end
        ST_PROG: begin
          if (sck_rise) begin
            rx_next      = rx_shift;
            bit_cnt_next = bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd7) begin
              spi_we       = 1'b1;
              bit_cnt_next = '0;
              addr_next    = addr_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      rx_reg      <= '0;
      op_reg      <= '0;
      addr_reg    <= '0;
      tx_reg      <= '0;
      id_idx_reg  <= '0;
      miso_reg    <= 1'b0;
      miso_en_reg <= 1'b0;
      cmd_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      rx_reg      <= rx_next;
      op_reg      <= op_next;
      addr_reg    <= addr_next;
      tx_reg      <= tx_next;
      id_idx_reg  <= id_idx_next;
      miso_reg    <= miso_next;
      miso_en_reg <= miso_en_next;
      cmd_err_reg <= cmd_err_next;
    end
  end

  // An SPI program byte takes priority over a coincident backdoor write.
  always_ff @(posedge clk_i) begin
    if (spi_we && !rst_i) begin
      mem[addr_reg] <= rx_shift;
    end else if (mem_we_i) begin
      mem[mem_addr_i] <= mem_wdata_i;
    end
  end

  assign mem_rdata_o   = mem[mem_addr_i];
  assign spi_miso_o    = miso_reg & ~csb_rise;
  assign spi_miso_en_o = miso_en_reg & ~csb_rise;
  assign busy_o        = ~csb_s & (state_reg != ST_IDLE);
  assign cmd_err_o     = cmd_err_reg;

endmodule

// File: tb/tb_chimera_spi_flash_resp.sv
// Directed bench for chimera_spi_flash_resp: an SPI host model drives
// transactions while a memory model predicts read data and contents.
module tb_chimera_spi_flash_resp;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_csb = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_en;
  logic       mem_we = 1'b0;
  logic [7:0] mem_addr = 8'h00;
  logic [7:0] mem_wdata = 8'h00;
  logic [7:0] mem_rdata;
  logic       busy, cmd_err;

  chimera_spi_flash_resp dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_csb_i     (spi_csb),
    .spi_sck_i     (spi_sck),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso),
    .spi_miso_en_o (spi_miso_en),
    .mem_we_i      (mem_we),
    .mem_addr_i    (mem_addr),
    .mem_wdata_i   (mem_wdata),
    .mem_rdata_o   (mem_rdata),
    .busy_o        (busy),
    .cmd_err_o     (cmd_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          err_cycles = 0;
  int          csb_hi_cnt = 0;
  logic        scan_en = 1'b0;
  logic [7:0]  model_mem [256];
  logic [7:0]  rx_buf [8];
  logic [7:0]  prog_buf [8];
  string       name_q [$];
  logic [31:0] act_q [$];
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    name_q.push_back(name);
    act_q.push_back(act);
    exp_q.push_back(exp);
  endtask

  // Single compare process: drains posted comparisons and checks memory
  // scans and the idle-line quiet state every cycle.
  always @(negedge clk) begin
    string       n;
    logic [31:0] a, e;
    while (name_q.size() > 0) begin
      n = name_q.pop_front();
      a = act_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
    end
    if (scan_en) begin
      checks++;
      if (mem_rdata !== model_mem[mem_addr]) begin
        failures++;
        $display("FAIL mem_scan[%02h] actual=%0h required=%0h", mem_addr, mem_rdata, model_mem[mem_addr]);
      end
    end
    if (cmd_err === 1'b1) err_cycles++;
    if (spi_csb) csb_hi_cnt++; else csb_hi_cnt = 0;
    if (csb_hi_cnt >= 4 && !rst) begin
      checks++;
      if ({spi_miso_en, spi_miso, busy} !== 3'b000) begin
        failures++;
        $display("FAIL idle_quiet actual=%b required=000", {spi_miso_en, spi_miso, busy});
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx, output int en_cnt);
    rx = 8'h00;
    en_cnt = 0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      #(HALF);
      rx = {rx[6:0], spi_miso};
      if (spi_miso_en === 1'b1) en_cnt++;
      spi_sck = 1'b1;
      #(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    spi_csb = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    spi_csb = 1'b1;
    #(4*HALF);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] rx;
    int         en;
    spi_bits(op, 8, rx, en);
    spi_bits(a[23:16], 8, rx, en);
    spi_bits(a[15:8], 8, rx, en);
    spi_bits(a[7:0], 8, rx, en);
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    mem_we = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    @(negedge clk);
    mem_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
    mem_addr = a;
    #2;
    d = mem_rdata;
    #8;
  endtask

  task automatic scan_all();
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      mem_addr = 8'(i);
      scan_en = 1'b1;
    end
    @(posedge clk);
    scan_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] rx;
    int         en;
    string      s;
    cs_start();
    send_hdr(8'h03, a);
    s = "";
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, rx, en);
      rx_buf[k] = rx;
      chk($sformatf("read_byte%0d", k), rx, model_mem[(int'(a[7:0]) + k) % 256]);
      chk($sformatf("read_en%0d", k), en, 8);
      s = {s, $sformatf(" %02h", rx)};
    end
    cs_end();
    $display("txn READ addr=%06h data=%s", a, s);
  endtask

  task automatic do_prog(input logic [23:0] a, input int nfull, input int nextra, input logic [7:0] extra);
    logic [7:0] rx;
    int         en;
    cs_start();
    send_hdr(8'h02, a);
    for (int k = 0; k < nfull; k++) begin
      spi_bits(prog_buf[k], 8, rx, en);
      model_mem[(int'(a[7:0]) + k) % 256] = prog_buf[k];
    end
    if (nextra > 0) spi_bits(extra, nextra, rx, en);
    cs_end();
    $display("txn PROG addr=%06h bytes=%0d partial_bits=%0d", a, nfull, nextra);
  endtask

  initial begin
    logic [7:0] rx, d;
    int         en;
    @(negedge clk);
    @(negedge clk);
    chk("rst_miso", spi_miso, 0);
    chk("rst_miso_en", spi_miso_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    @(negedge clk);
    $display("txn RESET released");

    for (int i = 0; i < 256; i++) bd_write(8'(i), 8'((i * 7 + 3) & 255));
    bd_write(8'h10, 8'h11);
    bd_write(8'h11, 8'h22);
    bd_write(8'h12, 8'h33);
    bd_write(8'h13, 8'h44);
    $display("txn PRELOAD 256 bytes");
    scan_all();

    do_read(24'h000010, 4);
    chk("lit_read0", rx_buf[0], 8'h11);
    chk("lit_read1", rx_buf[1], 8'h22);
    chk("lit_read2", rx_buf[2], 8'h33);
    chk("lit_read3", rx_buf[3], 8'h44);
    chk("no_err_after_read", err_cycles, 0);

    prog_buf[0] = 8'hAA;
    prog_buf[1] = 8'hBB;
    prog_buf[2] = 8'hCC;
    do_prog(24'h0000FE, 3, 0, 8'h00);
    bd_read(8'hFE, d);
    chk("lit_prog_fe", d, 8'hAA);
    bd_read(8'hFF, d);
    chk("lit_prog_ff", d, 8'hBB);
    bd_read(8'h00, d);
    chk("lit_prog_00", d, 8'hCC);
    scan_all();
    do_read(24'hAB00FE, 3);
    chk("lit_wrap_read2", rx_buf[2], 8'hCC);

    cs_start();
    spi_bits(8'h9F, 8, rx, en);
    for (int k = 0; k < 4; k++) begin
      spi_bits(8'h00, 8, rx, en);
      rx_buf[k] = rx;
      chk($sformatf("rdid_en%0d", k), en, 8);
    end
    chk("lit_rdid0", rx_buf[0], 8'hC2);
    chk("lit_rdid1", rx_buf[1], 8'h20);
    chk("lit_rdid2", rx_buf[2], 8'h18);
    chk("lit_rdid3", rx_buf[3], 8'h00);
    #(HALF);
    chk("rdid_en_before_csb", spi_miso_en, 1);
    spi_csb = 1'b1;
    #30;
    chk("rdid_en_3clk_after_csb", spi_miso_en, 0);
    chk("rdid_miso_3clk_after_csb", spi_miso, 0);
    #(4*HALF);
    $display("txn RDID id=%02h%02h%02h pad=%02h", rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]);

    cs_start();
    spi_bits(8'h55, 8, rx, en);
    spi_bits(8'h03, 8, rx, en);
    chk("bad_op_en_cnt", en, 0);
    spi_bits(8'hFF, 8, rx, en);
    chk("bad_op_en_cnt2", en, 0);
    cs_end();
    chk("bad_op_err_cycles", err_cycles, 1);
    $display("txn BADOP op=55 err_cycles=%0d", err_cycles);
    do_read(24'h000010, 2);
    scan_all();

    prog_buf[0] = 8'hAB;
    do_prog(24'h000020, 1, 4, 8'hF0);
    bd_read(8'h20, d);
    chk("lit_partial_20", d, 8'hAB);
    bd_read(8'h21, d);
    chk("lit_partial_21", d, 8'hEA);
    scan_all();

    cs_start();
    send_hdr(8'h02, 24'h000030);
    spi_bits(8'h5C, 7, rx, en);
    spi_mosi = 1'b0;
    #(HALF);
    spi_sck = 1'b1;
    #20;
    mem_we = 1'b1;
    mem_addr = 8'h30;
    mem_wdata = 8'hE1;
    #10;
    mem_we = 1'b0;
    #(HALF-30);
    spi_sck = 1'b0;
    cs_end();
    model_mem[8'h30] = 8'h5C;
    bd_read(8'h30, d);
    chk("lit_collision_30", d, 8'h5C);
    $display("txn PROG_COLLIDE addr=30 spi=5c backdoor=e1 result=%02h", d);

    cs_start();
    send_hdr(8'h03, 24'h000010);
    spi_bits(8'h00, 8, rx, en);
    chk("pre_rst_byte", rx, 8'h11);
    spi_bits(8'h00, 4, rx, en);
    rst = 1'b1;
    #10;
    chk("midrst_miso", spi_miso, 0);
    chk("midrst_miso_en", spi_miso_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    spi_bits(8'h03, 8, rx, en);
    spi_bits(8'h00, 8, rx, en);
    chk("csb_low_after_rst_en", en, 0);
    chk("csb_low_after_rst_busy", busy, 0);
    cs_end();
    $display("txn RESET_MID_READ");
    do_read(24'h000010, 4);
    chk("final_err_cycles", err_cycles, 1);
    scan_all();

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
